// File: rtl/div14_restoring_if.sv
// rtl/div14_restoring_if.sv - start/done request and result bundle for div14_restoring
interface div14_restoring_if #(
  parameter int N = 14
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div14_restoring.sv
// rtl/div14_restoring.sv - sequential restoring divider, one quotient bit per clock
// Results (quotient/remainder/div_by_zero) only change on entry to DONE or on reset.
module div14_restoring #(
  parameter int N = 14
) (
  input logic               i_clk,
  input logic               i_rst,
  div14_restoring_if.slave  bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [N-1:0]    r_quo_work;
  // Partial remainder stays below the divisor after every step, so its top
  // bit is always zero and only N bits are kept.
  logic [N-1:0]    r_rem_work;
  logic [N-1:0]    r_div;
  logic [CW-1:0]   r_count;

  logic            r_busy;
  logic            r_done;
  logic [N-1:0]    r_quotient;
  logic [N-1:0]    r_remainder;
  logic            r_dbz;

  logic [N:0]      w_shift;
  logic [N:0]      w_trial;
  logic            w_fits;
  logic [N-1:0]    w_rem_iter;
  logic [N-1:0]    w_quo_iter;
  logic            w_last;
  logic            w_div_zero;

  always_comb begin
    w_shift    = {r_rem_work, r_quo_work[N-1]};
    w_trial    = w_shift - {1'b0, r_div};
    w_fits     = ~w_trial[N];
    w_rem_iter = w_fits ? w_trial[N-1:0] : w_shift[N-1:0];
    w_quo_iter = {r_quo_work[N-2:0], w_fits};
    w_last     = (r_count == CW'(N - 1));
    w_div_zero = (bus.divisor == '0);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = w_div_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_quo_work  <= '0;
      r_rem_work  <= '0;
      r_div       <= '0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_busy <= (w_state_next == S_RUN);
      r_done <= (w_state_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_quo_work <= bus.dividend;
            r_div      <= bus.divisor;
            r_rem_work <= '0;
            r_count    <= '0;
            if (w_div_zero) begin
              r_quotient  <= '1;
              r_remainder <= bus.dividend;
              r_dbz       <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_quo_work <= w_quo_iter;
          r_rem_work <= w_rem_iter;
          r_count    <= r_count + CW'(1);
          // Final iteration publishes the freshly computed bit straight to the outputs.
          if (w_last) begin
            r_quotient  <= w_quo_iter;
            r_remainder <= w_rem_iter;
            r_dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;
endmodule
